cross_bar_slave_mem: RTL and testbench
======================================

Name: cross_bar_slave_mem

Overview:
- Responder model for one crossbar slave port.
- Accepts the req/addr/cmd/wdata request bundle that the crossbar drives on a slave port. Acks each request after a programmable number of wait states and serves reads and writes from a small internal word memory.
- Used as the bus-functional endpoint behind each slave port in subsystem simulation and in FPGA bring-up builds.

Parameters:
- ADDR_W, 32, width of the request address
- DATA_W, 32, width of write and read data
- MEM_DEPTH, 16, number of DATA_W words in internal memory; power of two, at least 2
- WAIT_CYCLES, 2, wait states between request capture and ack; range 0..255
- CNT_W, 16, width of the transaction statistics counters

Ports:
- clk  input  1  clock; all logic on the rising edge
- areset  input  1  asynchronous reset, active-high
- slave_req  input  1  request valid; held high by the crossbar until ack
- slave_addr  input  ADDR_W  byte address
- slave_cmd  input  1  0 = read, 1 = write
- slave_wdata  input  DATA_W  write data
- slave_ack  output  1  one-cycle acknowledge
- slave_rdata  output  DATA_W  read data; valid only in the ack cycle
- busy  output  1  high in WAIT and ACK states
- rd_cnt  output  CNT_W  completed reads, saturating
- wr_cnt  output  CNT_W  completed writes, saturating

Behaviour:
- Reset (async, areset=1): state=IDLE, wait counter=0, slave_ack=0, slave_rdata=0, busy=0, rd_cnt=0, wr_cnt=0, all memory words=0. Reset asserted mid-transaction drops that transaction: no ack, no memory write, no counter update.
- Word index: idx = slave_addr[$clog2(MEM_DEPTH)+1 : 2]. Upper address bits and bits [1:0] are ignored, so addresses alias modulo MEM_DEPTH*4.
- FSM has three states: IDLE, WAIT, ACK.
- IDLE:
  - On slave_req=1, capture cmd, idx and wdata and load the wait counter with WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, otherwise ACK.
- WAIT:
  - Decrement the counter each cycle; go to ACK when the counter reaches 1.
  - If slave_req drops to 0 (protocol violation), return to IDLE with no ack, no write and no count.
  - Input changes during WAIT are ignored; captured values are used.
- ACK (exactly one cycle):
  - slave_ack=1.
  - Read: slave_rdata = mem[idx], and rd_cnt increments.
  - Write: mem[idx] <= captured wdata at the end of this cycle, slave_rdata=0, and wr_cnt increments.
  - Next state is always IDLE.
- Outside ACK: slave_ack=0 and slave_rdata=0.
- Outputs are registered; slave_ack and slave_rdata have no combinational path from the inputs.
- Latency: slave_ack rises WAIT_CYCLES+1 cycles after the first cycle in which slave_req=1 is sampled in IDLE.
- Back-to-back: if slave_req is still high in the cycle after ACK, that cycle is a new request and is captured in IDLE. This gives a minimum of one idle cycle between acks, so sustained throughput is 1/(WAIT_CYCLES+2).
- Read-after-write to the same idx returns the new data, because the write completes before the next capture.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- busy = (state != IDLE).

Test Plan:
- Reset values: assert areset for 3 cycles with slave_req=1 -> slave_ack=0, slave_rdata=0, busy=0, rd_cnt=wr_cnt=0. Then a read of addr 0x0 returns 0x00000000.
- Write then read, WAIT_CYCLES=2: write 0xDEADBEEF to addr 0x8 with req held -> ack exactly 3 cycles after req, then one idle cycle. A read of 0x8 acks with rdata=0xDEADBEEF; wr_cnt=1, rd_cnt=1.
- Aliasing and WAIT_CYCLES=0, MEM_DEPTH=16: write 0x12345678 to 0x4 -> ack 1 cycle after req. A read of 0x44 returns 0x12345678; a read of 0x6 returns 0x12345678 because bits [1:0] are ignored.
- Request abort: read request to 0x0 with req dropped after 1 cycle in WAIT (WAIT_CYCLES=3) -> no ack, rd_cnt unchanged, FSM in IDLE next cycle. A following write request completes normally.
- Reset mid-write: assert areset in the WAIT cycle of a write of 0xA5A5A5A5 to 0xC -> no ack, wr_cnt=0, and a later read of 0xC returns 0.
- Saturation, CNT_W=2: perform 5 back-to-back reads with req held continuously -> 5 acks spaced WAIT_CYCLES+2 apart, and rd_cnt stays at 3 after the third ack.

Source files
------------

// File: rtl/cross_bar_slave_mem_if.sv
// Request/response bundle between one crossbar slave port and its responder.
// The crossbar side uses the master modport, the responder the slave modport.
interface cross_bar_slave_mem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              slave_req;
    logic [ADDR_W-1:0] slave_addr;
    logic              slave_cmd;
    logic [DATA_W-1:0] slave_wdata;
    logic              slave_ack;
    logic [DATA_W-1:0] slave_rdata;

    modport master (
        output slave_req, slave_addr, slave_cmd, slave_wdata,
        input  slave_ack, slave_rdata
    );

    modport slave (
        input  slave_req, slave_addr, slave_cmd, slave_wdata,
        output slave_ack, slave_rdata
    );
endinterface

// File: rtl/cross_bar_slave_mem.sv
// Crossbar slave-port responder: acks each request after WAIT_CYCLES wait states
// and serves reads/writes from a small word memory, with saturating statistics.
module cross_bar_slave_mem #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_DEPTH   = 16,
    parameter int WAIT_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   areset,
    cross_bar_slave_mem_if.slave   bus,
    output logic                   busy,
    output logic [CNT_W-1:0]       rd_cnt,
    output logic [CNT_W-1:0]       wr_cnt
);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [7:0] WAIT_INIT = 8'(WAIT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t            state;
    logic [7:0]        wait_cnt;
    logic              cmd_p0;
    logic [IDX_W-1:0]  idx_p0;
    logic [DATA_W-1:0] wdata_p0;
    logic [DATA_W-1:0] mem [MEM_DEPTH];
    logic [IDX_W-1:0]  req_idx;
    logic              unused_addr;

    // Byte address to word index; everything above the memory span aliases.
    assign req_idx     = bus.slave_addr[IDX_W+1:2];
    assign unused_addr = ^{bus.slave_addr[ADDR_W-1:IDX_W+2], bus.slave_addr[1:0]};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // Capture stage: request fields are frozen for the whole transaction.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && bus.slave_req) begin
            cmd_p0   <= bus.slave_cmd;
            idx_p0   <= req_idx;
            wdata_p0 <= bus.slave_wdata;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state           <= S_IDLE;
            wait_cnt        <= '0;
            bus.slave_ack   <= 1'b0;
            bus.slave_rdata <= '0;
            busy            <= 1'b0;
            rd_cnt          <= '0;
            wr_cnt          <= '0;
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.slave_req) begin
                        wait_cnt <= WAIT_INIT;
                        busy     <= 1'b1;
                        if (WAIT_CYCLES == 0) begin
                            state           <= S_ACK;
                            bus.slave_ack   <= 1'b1;
                            bus.slave_rdata <= bus.slave_cmd ? '0 : mem[req_idx];
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!bus.slave_req) begin
                        // Crossbar withdrew the request: drop it silently.
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                        wait_cnt <= '0;
                    end else if (wait_cnt <= 8'd1) begin
                        state           <= S_ACK;
                        wait_cnt        <= '0;
                        bus.slave_ack   <= 1'b1;
                        bus.slave_rdata <= cmd_p0 ? '0 : mem[idx_p0];
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                S_ACK: begin
                    state           <= S_IDLE;
                    busy            <= 1'b0;
                    bus.slave_ack   <= 1'b0;
                    bus.slave_rdata <= '0;
                    if (cmd_p0) begin
                        mem[idx_p0] <= wdata_p0;
                        wr_cnt      <= sat_inc(wr_cnt);
                    end else begin
                        rd_cnt <= sat_inc(rd_cnt);
                    end
                end
                default: begin
                    state         <= S_IDLE;
                    busy          <= 1'b0;
                    bus.slave_ack <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cross_bar_slave_mem.sv
// Directed bench for cross_bar_slave_mem: three instances cover WAIT_CYCLES 2/0/3,
// the first one also with CNT_W=2 for counter saturation.
module tb_cross_bar_slave_mem;
    logic clk = 1'b0;
    logic areset;
    always #5 clk = ~clk;

    cross_bar_slave_mem_if #(.ADDR_W(32), .DATA_W(32)) ifa ();
    cross_bar_slave_mem_if #(.ADDR_W(32), .DATA_W(32)) ifb ();
    cross_bar_slave_mem_if #(.ADDR_W(32), .DATA_W(32)) ifc ();

    logic        busy_a, busy_b, busy_c;
    logic [1:0]  rd_a, wr_a;
    logic [15:0] rd_b, wr_b, rd_c, wr_c;

    cross_bar_slave_mem #(.ADDR_W(32), .DATA_W(32), .MEM_DEPTH(16), .WAIT_CYCLES(2), .CNT_W(2)) dut_a (
        .clk(clk), .areset(areset), .bus(ifa), .busy(busy_a), .rd_cnt(rd_a), .wr_cnt(wr_a));
    cross_bar_slave_mem #(.ADDR_W(32), .DATA_W(32), .MEM_DEPTH(16), .WAIT_CYCLES(0), .CNT_W(16)) dut_b (
        .clk(clk), .areset(areset), .bus(ifb), .busy(busy_b), .rd_cnt(rd_b), .wr_cnt(wr_b));
    cross_bar_slave_mem #(.ADDR_W(32), .DATA_W(32), .MEM_DEPTH(16), .WAIT_CYCLES(3), .CNT_W(16)) dut_c (
        .clk(clk), .areset(areset), .bus(ifc), .busy(busy_c), .rd_cnt(rd_c), .wr_cnt(wr_c));

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        string       name;
        int          d;
        logic        cmd;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] rdata;
        int          rd;
        int          wr;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic set_req(input int d, input logic req, input logic cmd,
                           input logic [31:0] addr, input logic [31:0] wdata);
        case (d)
            0: begin ifa.slave_req = req; ifa.slave_cmd = cmd; ifa.slave_addr = addr; ifa.slave_wdata = wdata; end
            1: begin ifb.slave_req = req; ifb.slave_cmd = cmd; ifb.slave_addr = addr; ifb.slave_wdata = wdata; end
            default: begin ifc.slave_req = req; ifc.slave_cmd = cmd; ifc.slave_addr = addr; ifc.slave_wdata = wdata; end
        endcase
    endtask

    function automatic logic get_ack(input int d);
        case (d)
            0: return ifa.slave_ack;
            1: return ifb.slave_ack;
            default: return ifc.slave_ack;
        endcase
    endfunction

    function automatic logic [31:0] get_rdata(input int d);
        case (d)
            0: return ifa.slave_rdata;
            1: return ifb.slave_rdata;
            default: return ifc.slave_rdata;
        endcase
    endfunction

    function automatic logic get_busy(input int d);
        case (d)
            0: return busy_a;
            1: return busy_b;
            default: return busy_c;
        endcase
    endfunction

    function automatic logic [31:0] get_rd(input int d);
        case (d)
            0: return 32'(rd_a);
            1: return 32'(rd_b);
            default: return 32'(rd_c);
        endcase
    endfunction

    function automatic logic [31:0] get_wr(input int d);
        case (d)
            0: return 32'(wr_a);
            1: return 32'(wr_b);
            default: return 32'(wr_c);
        endcase
    endfunction

    // Counts negedges until ack is seen, bounded; a timeout shows up as a latency miss.
    task automatic wait_ack(input int d, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!get_ack(d) && n < 20);
    endtask

    // Called and returning at a negedge; one full request/ack/release sequence.
    task automatic do_txn(input vec_t v);
        int n;
        set_req(v.d, 1'b1, v.cmd, v.addr, v.wdata);
        wait_ack(v.d, n);
        check({v.name, " latency"}, 32'(n), 32'(v.lat));
        check({v.name, " rdata"}, get_rdata(v.d), v.rdata);
        set_req(v.d, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check({v.name, " ack one cycle"}, 32'(get_ack(v.d)), 32'd0);
        check({v.name, " idle after"}, 32'(get_busy(v.d)), 32'd0);
        check({v.name, " rd_cnt"}, get_rd(v.d), 32'(v.rd));
        check({v.name, " wr_cnt"}, get_wr(v.d), 32'(v.wr));
    endtask

    initial begin
        int n;
        int acks;
        int exp_rd;
        vec_t v;

        vecs[0] = '{"A rd 0x0 after reset", 0, 1'b0, 32'h0,  32'h0,        3, 32'h0,        1, 0};
        vecs[1] = '{"A wr 0x8",             0, 1'b1, 32'h8,  32'hDEADBEEF, 3, 32'h0,        1, 1};
        vecs[2] = '{"A rd 0x8",             0, 1'b0, 32'h8,  32'h0,        3, 32'hDEADBEEF, 2, 1};
        vecs[3] = '{"A wr 0x3C",            0, 1'b1, 32'h3C, 32'h11112222, 3, 32'h0,        2, 2};
        vecs[4] = '{"A rd 0x7C alias",      0, 1'b0, 32'h7C, 32'h0,        3, 32'h11112222, 3, 2};
        vecs[5] = '{"B wr 0x4",             1, 1'b1, 32'h4,  32'h12345678, 1, 32'h0,        0, 1};
        vecs[6] = '{"B rd 0x44 alias",      1, 1'b0, 32'h44, 32'h0,        1, 32'h12345678, 1, 1};
        vecs[7] = '{"B rd 0x6 low bits",    1, 1'b0, 32'h6,  32'h0,        1, 32'h12345678, 2, 1};
        vecs[8] = '{"C wr 0x10",            2, 1'b1, 32'h10, 32'hCAFEF00D, 4, 32'h0,        0, 1};
        vecs[9] = '{"C rd 0x10",            2, 1'b0, 32'h10, 32'h0,        4, 32'hCAFEF00D, 1, 1};

        // Reset held with requests pending on every instance.
        areset = 1'b1;
        for (int d = 0; d < 3; d++) set_req(d, 1'b1, 1'b1, 32'h8, 32'hFFFFFFFF);
        repeat (3) @(negedge clk);
        check("reset ack", 32'(ifa.slave_ack), 32'd0);
        check("reset rdata", ifa.slave_rdata, 32'h0);
        check("reset busy", 32'(busy_a), 32'd0);
        check("reset rd_cnt", 32'(rd_a), 32'd0);
        check("reset wr_cnt", 32'(wr_a), 32'd0);
        for (int d = 0; d < 3; d++) set_req(d, 1'b0, 1'b0, 32'h0, 32'h0);
        areset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) do_txn(vecs[i]);

        // Request withdrawn after one WAIT cycle on the WAIT_CYCLES=3 instance.
        set_req(2, 1'b1, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("abort busy in wait", 32'(busy_c), 32'd1);
        set_req(2, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("abort back to idle", 32'(busy_c), 32'd0);
        acks = 0;
        repeat (5) begin
            if (ifc.slave_ack) acks++;
            @(negedge clk);
        end
        check("abort no ack", 32'(acks), 32'd0);
        check("abort rd_cnt", 32'(rd_c), 32'd1);
        v = '{"C wr 0x14 after abort", 2, 1'b1, 32'h14, 32'h55AA55AA, 4, 32'h0, 1, 2};
        do_txn(v);
        v = '{"C rd 0x14", 2, 1'b0, 32'h14, 32'h0, 4, 32'h55AA55AA, 2, 2};
        do_txn(v);

        // Reset asserted while a write sits in WAIT.
        set_req(0, 1'b1, 1'b1, 32'hC, 32'hA5A5A5A5);
        @(negedge clk);
        check("midreset busy before", 32'(busy_a), 32'd1);
        areset = 1'b1;
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check("midreset busy async", 32'(busy_a), 32'd0);
        @(negedge clk);
        check("midreset ack", 32'(ifa.slave_ack), 32'd0);
        check("midreset wr_cnt", 32'(wr_a), 32'd0);
        areset = 1'b0;
        @(negedge clk);
        v = '{"A rd 0xC after midreset", 0, 1'b0, 32'hC, 32'h0, 3, 32'h0, 1, 0};
        do_txn(v);

        // Five back-to-back reads with req held; CNT_W=2 saturates at 3.
        set_req(0, 1'b1, 1'b0, 32'h8, 32'h0);
        wait_ack(0, n);
        for (int k = 1; k <= 5; k++) begin
            check($sformatf("b2b ack %0d spacing", k), 32'(n), (k == 1) ? 32'd3 : 32'd4);
            check($sformatf("b2b ack %0d rdata", k), ifa.slave_rdata, 32'h0);
            @(negedge clk);
            exp_rd = (1 + k > 3) ? 3 : 1 + k;
            check($sformatf("b2b rd_cnt after %0d", k), 32'(rd_a), 32'(exp_rd));
            check($sformatf("b2b gap %0d", k), 32'(ifa.slave_ack), 32'd0);
            if (k == 5) begin
                set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
            end else begin
                wait_ack(0, n);
                n = n + 1;
            end
        end
        repeat (3) @(negedge clk);
        check("b2b final idle", 32'(busy_a), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
